// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, DMA state encoding and data word type for the CNN datapath.
package cnn_pkg;
  localparam int DATA_SIZE = 16;
  localparam int BLOCK_SIZE = 25;
  typedef logic signed [DATA_SIZE-1:0] dataWord_t;
  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} dma_state_t;
  // A zero or oversized length means a full block.
  function automatic logic [4:0] clampLen(input logic [4:0] len);
    return (len == 5'd0 || len > 5'(BLOCK_SIZE)) ? 5'(BLOCK_SIZE) : len;
  endfunction
endpackage

// File: rtl/cnn_dma_engine_if.sv
// cnn_dma_engine_if: controller request port plus RAM port of the DMA engine.
interface cnn_dma_engine_if;
  import cnn_pkg::*;
  logic enable;
  logic loadEnable;
  logic writeEnable;
  logic [DATA_SIZE-1:0] address;
  logic [4:0] readLen;
  dataWord_t dataIn;
  dataWord_t [BLOCK_SIZE-1:0] blockOut;
  logic done;
  logic busy;
  logic err;
  logic [DATA_SIZE-1:0] memAddr;
  logic memRead;
  logic memWrite;
  logic [DATA_SIZE-1:0] memWData;
  logic [DATA_SIZE-1:0] memRData;
  modport slave(
    input enable, loadEnable, writeEnable, address, readLen, dataIn, memRData,
    output blockOut, done, busy, err, memAddr, memRead, memWrite, memWData
  );
  modport master(
    output enable, loadEnable, writeEnable, address, readLen, dataIn, memRData,
    input blockOut, done, busy, err, memAddr, memRead, memWrite, memWData
  );
endinterface

// File: rtl/cnn_block_buffer.sv
// cnn_block_buffer: BLOCK_SIZE-word read buffer with synchronous clear and indexed write.
module cnn_block_buffer
  import cnn_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic wrEn,
  input  logic [4:0] wrIdx,
  input  dataWord_t wrData,
  output dataWord_t [BLOCK_SIZE-1:0] blockOut
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) blockOut <= '0;
    else if (clear) blockOut <= '0;
    else if (wrEn)
      for (int i = 0; i < BLOCK_SIZE; i++)
        if (wrIdx == 5'(i)) blockOut[i] <= wrData;
endmodule

// File: rtl/cnn_dma_engine.sv
// cnn_dma_engine: turns single-word writes and block reads into 1-cycle-latency RAM cycles.
// Define CNN_DMA_BOUNDS_CHECK_EN to suppress and flag accesses at or beyond MEM_DEPTH.
module cnn_dma_engine
  import cnn_pkg::*;
#(
  parameter int MEM_DEPTH = 65536
) (
  input logic clk,
  input logic reset,
  cnn_dma_engine_if.slave bus
);
`ifdef CNN_DMA_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  dma_state_t state, nextState;
  logic enPrev, start, errFlag, oob, capture;
  logic [DATA_SIZE-1:0] baseAddr, reqAddr, wData;
  logic [4:0] len, k;
  assign start = bus.enable && !enPrev && state == IDLE;
  assign reqAddr = baseAddr + DATA_SIZE'(k);
  // Bounds compare uses the unwrapped address so a wrap past the top still counts as out of range.
  assign oob = BOUNDS_EN && (state == READ || state == WRITE) &&
               ({1'b0, baseAddr} + (DATA_SIZE+1)'(k) >= (DATA_SIZE+1)'(MEM_DEPTH));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE: nextState = !start ? IDLE : bus.loadEnable ? READ : bus.writeEnable ? WRITE : IDLE;
      READ: nextState = oob ? DONE : (k == len - 5'd1) ? DRAIN : READ;
      DRAIN, WRITE: nextState = DONE;
      default: nextState = IDLE;
    endcase
  end
  // Read data trails its issue by one cycle, so slot k-1 is captured while k is issued.
  always_comb begin
    bus.memRead = state == READ && !oob;
    bus.memWrite = state == WRITE && !oob;
    bus.memAddr = (state == READ || state == WRITE) ? reqAddr : '0;
    bus.memWData = state == WRITE ? wData : '0;
    bus.done = state == DONE;
    bus.busy = state != IDLE;
    bus.err = state == DONE && errFlag;
    capture = (state == READ && k != 5'd0) || state == DRAIN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      enPrev <= 1'b0;
      baseAddr <= '0;
      wData <= '0;
      len <= '0;
      k <= '0;
      errFlag <= 1'b0;
    end else begin
      enPrev <= bus.enable;
      if (start) begin
        baseAddr <= bus.address;
        wData <= bus.dataIn;
        len <= clampLen(bus.readLen);
        k <= '0;
        errFlag <= 1'b0;
      end else if (state == READ) k <= k + 5'd1;
      if (oob) errFlag <= 1'b1;
    end
  cnn_block_buffer u_buf (
    .clk(clk),
    .reset(reset),
    .clear(start && bus.loadEnable),
    .wrEn(capture),
    .wrIdx(k - 5'd1),
    .wrData(bus.memRData),
    .blockOut(bus.blockOut)
  );
endmodule

// File: tb/tb_cnn_dma_engine.sv
// tb_cnn_dma_engine: randomized scoreboard bench for cnn_dma_engine against a word-level memory model.
module tb_cnn_dma_engine;
`ifdef CNN_DMA_BOUNDS_CHECK_EN
  localparam int MEM_DEPTH = 'hFFF8;
  localparam bit BOUNDS_ON = 1'b1;
`else
  localparam int MEM_DEPTH = 65536;
  localparam bit BOUNDS_ON = 1'b0;
`endif
  typedef struct {
    logic [24:0][15:0] blk;
    bit err;
    int doneCyc;
  } exp_t;
  typedef struct {
    logic [15:0] addr;
    bit wr;
    logic [15:0] data;
  } memop_t;

  logic clk = 0;
  logic reset = 0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  logic [15:0] ram [65536];
  logic [15:0] refMem [65536];
  logic [24:0][15:0] lastBlock = '0;
  exp_t expQ[$];
  memop_t addrQ[$];
  exp_t e;
  memop_t m;

  cnn_dma_engine_if bus();
  cnn_dma_engine #(.MEM_DEPTH(MEM_DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.memWrite) ram[bus.memAddr] <= bus.memWData;
    if (bus.memRead) bus.memRData <= ram[bus.memAddr];
  end

  function automatic void chk(bit ok, string name, longint act, longint req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endfunction

  // Spec-level prediction: what the RAM sees and what completes, derived from the request alone.
  task automatic predict(input bit ld, input bit wr, input logic [15:0] a, input logic [4:0] len,
                         input logic [15:0] d, input int t);
    exp_t x;
    memop_t op;
    int n, v;
    if (!ld && !wr) return;
    x.err = 0;
    if (ld) begin
      n = (len == 0 || len > 25) ? 25 : int'(len);
      v = n;
      for (int i = 0; i < n; i++)
        if (BOUNDS_ON && (int'(a) + i) >= MEM_DEPTH) begin
          v = i;
          x.err = 1;
          break;
        end
      x.blk = '0;
      for (int i = 0; i < v; i++) begin
        op.addr = 16'(int'(a) + i);
        op.wr = 0;
        op.data = 0;
        x.blk[i] = refMem[op.addr];
        addrQ.push_back(op);
      end
      x.doneCyc = t + (x.err ? v : n) + 1;
      lastBlock = x.blk;
    end else begin
      x.blk = lastBlock;
      x.err = BOUNDS_ON && int'(a) >= MEM_DEPTH;
      if (!x.err) begin
        op.addr = a;
        op.wr = 1;
        op.data = d;
        addrQ.push_back(op);
        refMem[a] = d;
      end
      x.doneCyc = t + 1;
    end
    expQ.push_back(x);
  endtask

  task automatic issue(input bit ld, input bit wr, input logic [15:0] a, input logic [4:0] len,
                       input logic [15:0] d);
    @(negedge clk);
    predict(ld, wr, a, len, d, cyc + 1);
    bus.enable = 1;
    bus.loadEnable = ld;
    bus.writeEnable = wr;
    bus.address = a;
    bus.readLen = len;
    bus.dataIn = d;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(!bus.busy, "idle-timeout busy", longint'(bus.busy), 0);
  endtask

  task automatic xfer(input bit ld, input bit wr, input logic [15:0] a, input logic [4:0] len,
                      input logic [15:0] d);
    issue(ld, wr, a, len, d);
    waitIdle();
    bus.enable = 0;
  endtask

  // Monitor: every strobe and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (bus.memRead || bus.memWrite) begin
      if (addrQ.size() == 0) chk(0, "unexpected strobe memAddr", longint'(bus.memAddr), 0);
      else begin
        m = addrQ.pop_front();
        chk(bus.memAddr === m.addr, "memAddr", longint'(bus.memAddr), longint'(m.addr));
        chk(bus.memWrite === m.wr && bus.memRead === !m.wr, "strobe kind memWrite",
            longint'(bus.memWrite), longint'(m.wr));
        if (m.wr) chk(bus.memWData === m.data, "memWData", longint'(bus.memWData), longint'(m.data));
      end
    end
    if (bus.done) begin
      if (expQ.size() == 0) chk(0, "unexpected done", 1, 0);
      else begin
        e = expQ.pop_front();
        chk(cyc == e.doneCyc, "done cycle", longint'(cyc), longint'(e.doneCyc));
        chk(bus.err === e.err, "err", longint'(bus.err), longint'(e.err));
        chk(addrQ.size() == 0, "strobes missing before done", longint'(addrQ.size()), 0);
        tests++;
        if (bus.blockOut !== e.blk) begin
          fails++;
          $display("FAIL blockOut: got %h required %h", bus.blockOut, e.blk);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int kind;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'($urandom);
      refMem[i] = ram[i];
    end
    ram[16'h10] = 16'd5;      refMem[16'h10] = 16'd5;
    ram[16'h11] = 16'hFFFE;   refMem[16'h11] = 16'hFFFE;
    ram[16'h12] = 16'd7;      refMem[16'h12] = 16'd7;
    bus.enable = 0; bus.loadEnable = 0; bus.writeEnable = 0;
    bus.address = 0; bus.readLen = 0; bus.dataIn = 0;
    repeat (3) @(negedge clk);
    chk({bus.done, bus.busy, bus.err, bus.memRead, bus.memWrite} === 5'b0, "reset flags",
        longint'({bus.done, bus.busy, bus.err, bus.memRead, bus.memWrite}), 0);
    chk(bus.memAddr === 16'h0, "reset memAddr", longint'(bus.memAddr), 0);
    chk(bus.memWData === 16'h0, "reset memWData", longint'(bus.memWData), 0);
    chk(bus.blockOut === '0, "reset blockOut", longint'(bus.blockOut[0]), 0);
    reset = 1;
    xfer(1, 0, 16'h0010, 5'd3, 0);
    xfer(0, 1, 16'h0040, 5'd0, 16'hFFF7);
    xfer(1, 0, 16'h0040, 5'd1, 0);
    xfer(1, 0, 16'hFFF0, 5'd0, 0);
    xfer(1, 1, 16'h0020, 5'd31, 0);
    // Level-held enable across done must not retrigger.
    issue(1, 0, 16'h0100, 5'd4, 0);
    waitIdle();
    repeat (4) @(negedge clk);
    bus.enable = 0;
    xfer(1, 0, 16'h0100, 5'd4, 0);
    // Neither load nor write: dropped with no done.
    xfer(0, 0, 16'h0500, 5'd2, 0);
    repeat (3) @(negedge clk);
    // A fresh start while busy is ignored, so RAM[0x301] stays intact.
    issue(1, 0, 16'h0300, 5'd8, 0);
    @(negedge clk); bus.enable = 0;
    @(negedge clk); bus.enable = 1; bus.loadEnable = 0; bus.writeEnable = 1;
    bus.address = 16'h0301; bus.dataIn = 16'h1234;
    waitIdle();
    bus.enable = 0;
    xfer(1, 0, 16'h0301, 5'd1, 0);
    // Reset in the middle of a read.
    issue(1, 0, 16'h0200, 5'd10, 0);
    found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      found = bus.memRead && bus.memAddr == 16'h0204;
    end
    chk(found, "reached k=4 found", longint'(found), 1);
    #2 reset = 0;
    #1;
    chk({bus.memRead, bus.busy, bus.done} === 3'b0, "async reset flags",
        longint'({bus.memRead, bus.busy, bus.done}), 0);
    chk(bus.blockOut === '0, "async reset blockOut", longint'(bus.blockOut[0]), 0);
    expQ.delete();
    addrQ.delete();
    lastBlock = '0;
    bus.enable = 0;
    @(negedge clk);
    reset = 1;
    xfer(1, 0, 16'h0010, 5'd3, 0);
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, 1) ? 16'($urandom) : 16'(16'hFFE0 + $urandom_range(0, 31));
      xfer(kind < 5, kind >= 5 && kind < 9, a, 5'($urandom), 16'($urandom));
    end
    repeat (5) @(negedge clk);
    chk(expQ.size() == 0 && addrQ.size() == 0, "scoreboard drained pending",
        longint'(expQ.size() + addrQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cnn_dma_engine.md
# cnn_dma_engine

Memory-side transfer engine directly downstream of the CNN controller's DMA request port. It turns single-word write requests and block-read requests into cycles on a synchronous single-port data RAM. Read results land in a BLOCK_SIZE-word buffer that the controller, convolution layer and pool layer consume as `memFetchResult`. It is the executor behind `dmaEnable`/`loadEnable`/`writeEnable`/`dmaAddress`/`dmaInput`/`dmaDone`.

## Interface
- DATA_SIZE, 16, word and address width
- BLOCK_SIZE, 25, read-buffer depth in words
- MEM_DEPTH, 65536, number of valid RAM words (used only by bounds check)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- enable  in  1  request strobe (`dmaEnable`); start on rising edge only
- loadEnable  in  1  request is a block read
- writeEnable  in  1  request is a single-word write (ignored if loadEnable=1)
- address  in  DATA_SIZE  base word address (`dmaAddress`)
- readLen  in  5  words to read, 1..BLOCK_SIZE; 0 or >BLOCK_SIZE means BLOCK_SIZE
- dataIn  in  DATA_SIZE signed  write data (`dmaInput`)
- blockOut  out  DATA_SIZE signed x BLOCK_SIZE  read buffer (`memFetchResult`)
- done  out  1  one-cycle completion pulse (`dmaDone`)
- busy  out  1  high from accept until done cycle inclusive
- err  out  1  sticky-per-request error flag, valid with done (bounds check only)
- memAddr  out  DATA_SIZE  RAM address
- memRead  out  1  RAM read strobe; data returns next cycle
- memWrite  out  1  RAM write strobe
- memWData  out  DATA_SIZE  RAM write data
- memRData  in  DATA_SIZE  RAM read data, 1-cycle latency

## Operation
- States: IDLE, READ, DRAIN, WRITE, DONE.
- Start detect: register `enable`. A request is accepted in IDLE when enable=1 and the previous-cycle enable=0. A level-held enable never retriggers.
- IDLE -> READ when start and loadEnable=1.
  - Latch address, N = clamped readLen, and k=0.
  - Clear blockOut to 0.
- IDLE -> WRITE when start, loadEnable=0 and writeEnable=1.
  - Latch address and dataIn.
- A start with neither loadEnable nor writeEnable set is dropped. No done is produced.
- READ:
  - Each cycle: memRead=1, memAddr=address+k, k++.
  - Data returned for k-1 is written to blockOut[k-1].
  - After the cycle that issues k=N-1 -> DRAIN.
- DRAIN: capture blockOut[N-1], memRead=0 -> DONE.
- WRITE: one cycle with memWrite=1, memAddr=address, memWData=dataIn -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- blockOut holds its value until the next accepted read. Writes never alter it.
- Address arithmetic: address+k is computed modulo 2^DATA_SIZE and wraps silently from 0xFFFF to 0x0000.
- Entries blockOut[N..BLOCK_SIZE-1] read 0 after a read of N words.
- Any start occurring while not IDLE is ignored, not queued.
- Reset mid-operation: memRead, memWrite, done, busy and err go low asynchronously; the state machine returns to IDLE. Reset does not undo a RAM write already issued.

## Timing
- Reset values:
  - blockOut all 0, done 0, busy 0, err 0.
  - memAddr 0, memRead 0, memWrite 0, memWData 0.
  - State IDLE, previous-cycle enable 0.
- Read of N words: start sampled at edge T. memRead is high T+1..T+N, DRAIN is at T+N+1, done is high at T+N+2. blockOut is valid from T+N+2.
- Write: start sampled at edge T. memWrite is high T+1, done is high T+2.
- busy is high the cycle after accept through the done cycle.
- Back-to-back: the earliest next accept is the cycle after done, provided enable has toggled low in between.

## Configuration
- CNN_DMA_BOUNDS_CHECK_EN defined:
  - Before each issue, compare address+k (unwrapped, DATA_SIZE+1 bits) against MEM_DEPTH.
  - If it is >= MEM_DEPTH, suppress the strobe and go to DONE with err=1. blockOut keeps the words captured so far; the rest stay 0.
  - A write to an out-of-range address is likewise suppressed, with err=1.
- CNN_DMA_BOUNDS_CHECK_EN undefined:
  - No comparison is made; addresses wrap as stated above.
  - err is tied to 0.

## Structure
- Shared package `cnn_pkg`:
  - DATA_SIZE, BLOCK_SIZE.
  - The dma_state_t enum (IDLE, READ, DRAIN, WRITE, DONE).
  - The typedef for a signed data word.
- One sub-module: `cnn_block_buffer`, the BLOCK_SIZE-entry register file with synchronous clear and indexed write, which drives blockOut.

## Test plan
- Reset, then read address=0x0010, readLen=3, RAM[0x10..0x12]={5,-2,7} -> done at T+5; blockOut[0..2]={5,-2,7}, blockOut[3..24]=0.
- Write address=0x0040, dataIn=-9 -> memWrite one cycle at T+1, done at T+2; a following 1-word read at 0x40 returns -9.
- readLen=0 at address 0xFFF0 -> 25 reads with memAddr wrapping 0xFFFF->0x0000; done at T+27; no err (macro off). With macro on and MEM_DEPTH=0xFFF8 -> err=1, blockOut[0..7] filled, rest 0.
- Hold enable high across done -> exactly one done pulse; dropping enable and raising it again gives a second transfer.
- Assert reset low during READ at k=4 -> memRead, busy and done are 0 immediately, blockOut is all 0; the next request completes normally.
